// File: rtl/instr_fetch.sv
// Instruction fetch sequencer: walks PC through a combinational ROM and hands
// decoded packets to execute. Two-word assembly exists only with INSTR_FETCH_TWO_WORD_EN.
module instr_fetch (
  input  logic        clk,
  input  logic        rst_n,
  output logic [7:0]  PC,
  input  logic [15:0] rom_data,
  output logic        ir_valid,
  input  logic        ir_ready,
  output logic [15:0] ir,
  output logic [15:0] ir_ext,
  output logic [7:0]  ir_pc,
  output logic [7:0]  ret_pc,
  input  logic        redirect,
  input  logic [7:0]  redirect_pc
);

  logic slot_free;
  assign slot_free = !ir_valid || ir_ready;

`ifdef INSTR_FETCH_TWO_WORD_EN
  typedef enum logic {FETCH, FETCH_EXT} state_t;

  state_t      state;
  logic [15:0] word0;
  logic [7:0]  word0_pc;
  logic        two_word;

  // LRLI and CALL carry an immediate/target in the following ROM word
  assign two_word = (rom_data[15:14] == 2'b10) &&
                    ((rom_data[13:9] == 5'b00010) || (rom_data[13:9] == 5'b01110));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= FETCH;
      PC       <= 8'h00;
      ir_valid <= 1'b0;
      ir       <= 16'h0000;
      ir_ext   <= 16'h0000;
      ir_pc    <= 8'h00;
      ret_pc   <= 8'h00;
      word0    <= 16'h0000;
      word0_pc <= 8'h00;
    end else if (redirect) begin
      // a partial word0 is abandoned simply by returning to FETCH
      state    <= FETCH;
      PC       <= redirect_pc;
      ir_valid <= 1'b0;
    end else if (slot_free) begin
      case (state)
        FETCH: begin
          PC <= PC + 8'd1;
          if (two_word) begin
            word0    <= rom_data;
            word0_pc <= PC;
            ir_valid <= 1'b0;
            state    <= FETCH_EXT;
          end else begin
            ir       <= rom_data;
            ir_ext   <= 16'h0000;
            ir_pc    <= PC;
            ret_pc   <= PC + 8'd1;
            ir_valid <= 1'b1;
          end
        end
        FETCH_EXT: begin
          ir       <= word0;
          ir_ext   <= rom_data;
          ir_pc    <= word0_pc;
          ret_pc   <= PC + 8'd1;
          ir_valid <= 1'b1;
          PC       <= PC + 8'd1;
          state    <= FETCH;
        end
        default: state <= FETCH;
      endcase
    end
  end
`else
  assign ir_ext = 16'h0000;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      PC       <= 8'h00;
      ir_valid <= 1'b0;
      ir       <= 16'h0000;
      ir_pc    <= 8'h00;
      ret_pc   <= 8'h00;
    end else if (redirect) begin
      PC       <= redirect_pc;
      ir_valid <= 1'b0;
    end else if (slot_free) begin
      ir       <= rom_data;
      ir_pc    <= PC;
      ret_pc   <= PC + 8'd1;
      ir_valid <= 1'b1;
      PC       <= PC + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: directed scenarios, then random ready/redirect traffic
// checked against an in-order packet model derived from ROM contents.
module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  PC;
  logic [15:0] rom_data;
  logic        ir_valid;
  logic        ir_ready;
  logic [15:0] ir;
  logic [15:0] ir_ext;
  logic [7:0]  ir_pc;
  logic [7:0]  ret_pc;
  logic        redirect;
  logic [7:0]  redirect_pc;

  logic [15:0] rom [256];
  int checks = 0;
  int errors = 0;

`ifdef INSTR_FETCH_TWO_WORD_EN
  localparam bit TW = 1'b1;
`else
  localparam bit TW = 1'b0;
`endif

  assign rom_data = rom[PC];
  always #5 clk = ~clk;

  instr_fetch dut (
    .clk(clk), .rst_n(rst_n), .PC(PC), .rom_data(rom_data),
    .ir_valid(ir_valid), .ir_ready(ir_ready), .ir(ir), .ir_ext(ir_ext),
    .ir_pc(ir_pc), .ret_pc(ret_pc), .redirect(redirect), .redirect_pc(redirect_pc)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic bit is_two(input logic [15:0] w);
    return TW && (w[15:14] == 2'b10) && (w[13:9] == 5'b00010 || w[13:9] == 5'b01110);
  endfunction

  task automatic chk_pkt(input string tag, input logic [15:0] e_ir, input logic [15:0] e_ext,
                         input logic [7:0] e_pc, input logic [7:0] e_ret);
    chk({tag, "_valid"}, ir_valid, 1'b1);
    chk({tag, "_ir"}, ir, e_ir);
    chk({tag, "_ext"}, ir_ext, e_ext);
    chk({tag, "_pc"}, ir_pc, e_pc);
    chk({tag, "_ret"}, ret_pc, e_ret);
  endtask

  task automatic do_redirect(input logic [7:0] tgt);
    redirect = 1'b1;
    redirect_pc = tgt;
    tick();
    redirect = 1'b0;
    chk("redir_valid", ir_valid, 1'b0);
    chk("redir_pc", PC, tgt);
  endtask

  initial begin
    logic [15:0] e_ir, e_ext;
    logic [7:0]  e_pc, exp_addr, a;
    logic [15:0] h_ir, h_ext;
    logic [7:0]  h_pc, h_ret;
    logic        hold_prev;
    logic        two;
    int          accepted;

    for (int i = 0; i < 256; i++) rom[i] = 16'h0000;
    rom[0] = 16'h4000; rom[1] = 16'h0901; rom[2] = 16'h1201;
    rom[5] = 16'h8449; rom[6] = 16'h0001; rom[7] = 16'h1234;
    rom[8'h10] = 16'h9C04; rom[8'h11] = 16'h5555; rom[8'h20] = 16'h0A0A;
    rom[8'hFF] = 16'h9C04;

    rst_n = 1'b0; ir_ready = 1'b1; redirect = 1'b0; redirect_pc = 8'h00;
    #12;
    chk("rst_pc", PC, 8'h00);
    chk("rst_valid", ir_valid, 1'b0);
    chk("rst_ir", ir, 16'h0000);
    chk("rst_ext", ir_ext, 16'h0000);
    chk("rst_irpc", ir_pc, 8'h00);
    chk("rst_ret", ret_pc, 8'h00);
    rst_n = 1'b1;

    // back-to-back one-word stream
    tick(); chk_pkt("seq0", 16'h4000, 16'h0000, 8'h00, 8'h01);
    tick(); chk_pkt("seq1", 16'h0901, 16'h0000, 8'h01, 8'h02);
    tick(); chk_pkt("seq2", 16'h1201, 16'h0000, 8'h02, 8'h03);
    chk("seq_nextpc", PC, 8'h03);

    // LRLI at 5
    do_redirect(8'h05);
`ifdef INSTR_FETCH_TWO_WORD_EN
    tick(); chk("lrli_gap_valid", ir_valid, 1'b0); chk("lrli_gap_pc", PC, 8'h06);
    tick(); chk_pkt("lrli", 16'h8449, 16'h0001, 8'h05, 8'h07);
    e_ir = 16'h8449; e_ext = 16'h0001; e_pc = 8'h05;
`else
    tick(); chk_pkt("lrli_alone", 16'h8449, 16'h0000, 8'h05, 8'h06);
    tick(); chk_pkt("lrli_word1", 16'h0001, 16'h0000, 8'h06, 8'h07);
    e_ir = 16'h0001; e_ext = 16'h0000; e_pc = 8'h06;
`endif
    chk("lrli_nextpc", PC, 8'h07);

    // stall for 3 clocks
    ir_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("stall_valid", ir_valid, 1'b1);
      chk("stall_pc", PC, 8'h07);
      chk("stall_ir", ir, e_ir);
      chk("stall_ext", ir_ext, e_ext);
      chk("stall_irpc", ir_pc, e_pc);
    end
    ir_ready = 1'b1;
    tick(); chk_pkt("release", 16'h1234, 16'h0000, 8'h07, 8'h08);

    // redirect while CALL at 0x10 is half-assembled
    do_redirect(8'h10);
    tick();
    chk("call_pc", PC, 8'h11);
`ifdef INSTR_FETCH_TWO_WORD_EN
    chk("call_partial_valid", ir_valid, 1'b0);
`else
    chk_pkt("call_alone", 16'h9C04, 16'h0000, 8'h10, 8'h11);
`endif
    do_redirect(8'h20);
    tick(); chk_pkt("redir_tgt", 16'h0A0A, 16'h0000, 8'h20, 8'h21);

    // CALL at 0xFF wraps for its second word
    rom[0] = 16'h0004;
    do_redirect(8'hFF);
`ifdef INSTR_FETCH_TWO_WORD_EN
    tick(); chk("wrap_gap_valid", ir_valid, 1'b0); chk("wrap_gap_pc", PC, 8'h00);
    tick(); chk_pkt("wrap", 16'h9C04, 16'h0004, 8'hFF, 8'h01);
    chk("wrap_nextpc", PC, 8'h01);
`else
    tick(); chk_pkt("wrap", 16'h9C04, 16'h0000, 8'hFF, 8'h00);
    chk("wrap_nextpc", PC, 8'h00);
`endif

    // async reset in the middle of a two-word fetch
    do_redirect(8'h05);
    tick();
    #3 rst_n = 1'b0;
    #1;
    chk("arst_pc", PC, 8'h00);
    chk("arst_valid", ir_valid, 1'b0);
    chk("arst_ir", ir, 16'h0000);
    chk("arst_ext", ir_ext, 16'h0000);
    chk("arst_irpc", ir_pc, 8'h00);
    chk("arst_ret", ret_pc, 8'h00);
    rom[0] = 16'h4000;
    #2 rst_n = 1'b1;
    tick(); chk_pkt("restart", 16'h4000, 16'h0000, 8'h00, 8'h01);

    // reset beats redirect
    redirect = 1'b1; redirect_pc = 8'h33; rst_n = 1'b0;
    tick();
    chk("rst_vs_redir_pc", PC, 8'h00);
    chk("rst_vs_redir_valid", ir_valid, 1'b0);
    redirect = 1'b0;

    // random phase
    for (int i = 0; i < 256; i++) begin
      if ($urandom_range(3) == 0)
        rom[i] = {2'b10, ($urandom_range(1) == 1) ? 5'b00010 : 5'b01110, 9'($urandom)};
      else
        rom[i] = 16'($urandom);
    end
    #4 rst_n = 1'b1;
    tick();
    exp_addr = 8'h00;
    hold_prev = 1'b0;
    accepted = 0;
    h_ir = '0; h_ext = '0; h_pc = '0; h_ret = '0;
    for (int c = 0; c < 3000; c++) begin
      if (hold_prev) begin
        chk("hold_valid", ir_valid, 1'b1);
        chk("hold_ir", ir, h_ir);
        chk("hold_ext", ir_ext, h_ext);
        chk("hold_irpc", ir_pc, h_pc);
        chk("hold_ret", ret_pc, h_ret);
      end
      ir_ready = ($urandom_range(9) < 7);
      redirect = ($urandom_range(19) == 0);
      redirect_pc = 8'($urandom);
      if (ir_valid && ir_ready) begin
        a = exp_addr;
        two = is_two(rom[a]);
        chk("rnd_ir", ir, rom[a]);
        chk("rnd_ext", ir_ext, two ? rom[8'(a + 8'd1)] : 16'h0000);
        chk("rnd_irpc", ir_pc, a);
        chk("rnd_ret", ret_pc, two ? 8'(a + 8'd2) : 8'(a + 8'd1));
        exp_addr = two ? 8'(a + 8'd2) : 8'(a + 8'd1);
        accepted++;
      end
      if (redirect) exp_addr = redirect_pc;
      hold_prev = ir_valid && !ir_ready && !redirect;
      h_ir = ir; h_ext = ir_ext; h_pc = ir_pc; h_ret = ret_pc;
      tick();
    end
    redirect = 1'b0;
    chk("rnd_progress", accepted > 300, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/instr_fetch.md
# instr_fetch

Instruction fetch sequencer for the 16-bit processor. Drives the 8-bit `PC` address into the combinational instruction ROM, captures the returned word, assembles two-word instructions (LRLI, CALL) into one packet, and hands packets to the decode/execute stage over a valid/ready handshake. It also accepts branch, call and return redirects from execute.

## Interface
- No parameters. Widths are fixed: address 8, instruction 16.
- `clk`  in  1  single clock, rising-edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `PC`  out  8  ROM address. The ROM returns `rom_data` combinationally in the same cycle.
- `rom_data`  in  16  instruction word at `PC`.
- `ir_valid`  out  1  packet available to execute.
- `ir_ready`  in  1  execute accepts the packet this cycle.
- `ir`  out  16  first (opcode) word of the packet.
- `ir_ext`  out  16  second word for two-word instructions; 16'h0000 otherwise.
- `ir_pc`  out  8  address of `ir`.
- `ret_pc`  out  8  address after the packet (`ir_pc`+1 or +2). Execute pushes this on CALL.
- `redirect`  in  1  execute requests a fetch from `redirect_pc`.
- `redirect_pc`  in  8  new fetch address.

## Operation
- Two-word detect applies to the ROM word: `[15:14]==2'b10` and `[13:9]` is `5'b00010` (LRLI) or `5'b01110` (CALL). All other encodings are one word.
- States:
  - FETCH: primary word.
  - FETCH_EXT: second word.
- Slot free means `!ir_valid || ir_ready`.
- FETCH, slot free, one-word instruction:
  - Load `ir` from `rom_data`, `ir_ext` with 0, `ir_pc` with `PC`, and `ret_pc` with `PC`+1.
  - Set `ir_valid`=1 and `PC`=`PC`+1.
  - Stay in FETCH.
- FETCH, slot free, two-word instruction:
  - Latch the word into an internal `word0` register and its address into `word0_pc`. Set `PC`=`PC`+1.
  - Go to FETCH_EXT.
  - If `ir_ready` was high, `ir_valid` drops to 0.
- FETCH_EXT, slot free:
  - Load `ir`=`word0`, `ir_ext`=`rom_data`, `ir_pc`=`word0_pc`, `ret_pc`=`PC`+1.
  - Set `ir_valid`=1 and `PC`=`PC`+1.
  - Go to FETCH.
- Slot not free, either state: hold `PC`, state and all outputs.
- `ir`, `ir_ext`, `ir_pc` and `ret_pc` are stable while `ir_valid`=1 and `ir_ready`=0.
- `redirect` has the highest priority:
  - Sets `PC`=`redirect_pc`, clears `ir_valid`, and discards any partial `word0`.
  - Forces FETCH regardless of `ir_ready` and state.
  - A packet accepted in the same cycle as `redirect` counts as consumed.
  - Data registers may hold stale values after a redirect. Only `ir_valid` is meaningful.
- `PC` arithmetic is modulo 256: 8'hFF+1 wraps to 8'h00.
  - A two-word instruction at 8'hFF takes its second word from 8'h00.
  - Its `ret_pc` is 8'h01.

## Timing
- Reset values (asynchronous, while `rst_n`=0):
  - `PC`=8'h00, `ir_valid`=0.
  - `ir`, `ir_ext`, `ir_pc`, `ret_pc` all 0.
  - `word0`=0, state FETCH.
- First edge after reset release: a one-word instruction at 0 gives `ir_valid`=1 after that edge.
- Latency:
  - One-word instruction: 1 clock from `PC` presentation to `ir_valid`.
  - Two-word instruction: 2 clocks.
- Throughput:
  - One-word: one packet per clock with `ir_ready` held high.
  - Two-word: one packet per 2 clocks.
- Redirect: the target word is on `PC` in the cycle after `redirect` is sampled. First valid packet appears 1 clock later (2 clocks if the target is two-word).
- Reset asserted mid-operation, including in FETCH_EXT, returns everything to reset values immediately.
- `redirect` and `rst_n` low together: reset wins.

## Configuration
- `INSTR_FETCH_TWO_WORD_EN`
  - Defined: two-word assembly and the FETCH_EXT state exist, as described above.
  - Undefined: every ROM word is a one-word packet, `ir_ext` is tied to 16'h0000, `ret_pc`=`ir_pc`+1, and no FETCH_EXT state or `word0` register is synthesized.

## Test plan
- Reset, then ROM[0..2]=16'h4000,16'h0901,16'h1201 with `ir_ready`=1 -> `ir_valid` high from edge 1. `ir` sequence 4000, 0901, 1201 with `ir_pc` 0, 1, 2 and `ret_pc` 1, 2, 3, on consecutive clocks.
- ROM[5]=16'h8449 (LRLI), ROM[6]=16'h0001, PC starts at 5 -> one packet, `ir`=8449, `ir_ext`=0001, `ir_pc`=5, `ret_pc`=7, 2 clocks after PC=5; next fetch at 7.
- `ir_ready`=0 for 3 clocks with a packet valid -> `PC`, `ir`, `ir_pc` and `ir_ext` unchanged. On release, the next packet follows 1 clock later.
- `redirect`=1, `redirect_pc`=8'h20, asserted in FETCH_EXT of a CALL (ROM word 16'h9C04) -> partial CALL dropped, `ir_valid`=0, `PC`=8'h20 next cycle. ROM[8'h20]'s instruction is valid 1 clock later.
- CALL word at 8'hFF, second word 16'h0004 at 8'h00 -> `ir_pc`=8'hFF, `ir_ext`=0004, `ret_pc`=8'h01.
- `rst_n` pulsed low asynchronously mid-stream -> all outputs 0 without waiting for a clock edge. Fetch restarts at 0. Repeat the sequence with `INSTR_FETCH_TWO_WORD_EN` undefined -> 8449 is issued alone with `ir_ext`=0.
